// File: rtl/prim_subreg_shadow.sv
// prim_subreg_shadow
//
// Shadowed register field for security-critical CSRs. Software has to write
// the same value twice in a row before it lands in the committed copy. The
// committed copy is kept next to an inverted shadow copy so that a disturbed
// storage bit is flagged continuously.
//
// Parameters:
//   DW        field width in bits (1..32)
//   SWACCESS  software access mode: "RW", "WO", "W1C", "W1S" or "W0C"
//   RESVAL    reset value of the committed copy
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   re           software read pulse, abandons a half-finished write pair
//   we, wd       software write pulse and data
//   de, d        hardware write enable and data
//   qe           one-cycle pulse after a successful software commit
//   q, qs        committed value (hardware view / software read view)
//   phase        0 = waiting for first write, 1 = waiting for confirmation
//   err_update   one-cycle pulse when the confirming write differs
//   err_storage  committed copy and shadow copy disagree
//
// Build option:
//   PRIM_SUBREG_SHADOW_ERR_STICKY_EN - when defined, err_storage is a
//   registered flag that stays set until reset.

module prim_subreg_shadow #(
    parameter int              DW       = 32,
    parameter string           SWACCESS = "RW",
    parameter logic [DW-1:0]   RESVAL   = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          re,
    input  logic          we,
    input  logic [DW-1:0] wd,
    input  logic          de,
    input  logic [DW-1:0] d,
    output logic          qe,
    output logic [DW-1:0] q,
    output logic [DW-1:0] qs,
    output logic          phase,
    output logic          err_update,
    output logic          err_storage
);

    localparam bit IsRw  = (SWACCESS == "RW");
    localparam bit IsWo  = (SWACCESS == "WO");
    localparam bit IsW1c = (SWACCESS == "W1C");
    localparam bit IsW1s = (SWACCESS == "W1S");
    localparam bit IsW0c = (SWACCESS == "W0C");

    // Read-only style modes make no sense for a field that needs two writes.
    if (!(IsRw || IsWo || IsW1c || IsW1s || IsW0c)) begin : gen_bad_swaccess
        $error("prim_subreg_shadow: unsupported SWACCESS mode");
    end
    if (DW < 1 || DW > 32) begin : gen_bad_dw
        $error("prim_subreg_shadow: DW must be within 1..32");
    end

    logic [DW-1:0] staged_q;
    logic [DW-1:0] committed_q;
    logic [DW-1:0] shadow_q;
    logic          phase_q;
    logic          qe_q;
    logic          errUpdate_q;

    logic [DW-1:0] nv;
    logic          swCommit;
    logic          swMismatch;
    logic          storageMismatch;

    // Set/clear modes are evaluated against the current committed value, so a
    // hardware update between the two writes can legitimately cause the
    // confirmation to mismatch.
    always_comb begin
        nv = wd;
        if (IsW1s) begin
            nv = committed_q | wd;
        end else if (IsW1c) begin
            nv = committed_q & ~wd;
        end else if (IsW0c) begin
            nv = committed_q & wd;
        end
    end

    assign swCommit        = we && phase_q && (nv == staged_q);
    assign swMismatch      = we && phase_q && (nv != staged_q);
    assign storageMismatch = (committed_q != ~shadow_q);

    // Write-pair bookkeeping: the first write stages a value, any read
    // abandons the pair after the current write has been handled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            staged_q <= RESVAL;
            phase_q  <= 1'b0;
        end else begin
            if (we && !phase_q) begin
                staged_q <= nv;
            end
            if (re) begin
                phase_q <= 1'b0;
            end else if (we) begin
                phase_q <= ~phase_q;
            end
        end
    end

    // Committed and shadow copies always move together; a successful
    // software commit takes priority over a simultaneous hardware write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            committed_q <= RESVAL;
            shadow_q    <= ~RESVAL;
        end else if (swCommit) begin
            committed_q <= nv;
            shadow_q    <= ~nv;
        end else if (de) begin
            committed_q <= d;
            shadow_q    <= ~d;
        end
    end

    // Single-cycle event pulses for commit and update mismatch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            qe_q        <= 1'b0;
            errUpdate_q <= 1'b0;
        end else begin
            qe_q        <= swCommit;
            errUpdate_q <= swMismatch;
        end
    end

`ifdef PRIM_SUBREG_SHADOW_ERR_STICKY_EN
    logic errStorage_q;

    // Once a storage fault has been seen it is remembered until reset, even
    // if a later write makes the copies consistent again.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            errStorage_q <= 1'b0;
        end else begin
            errStorage_q <= errStorage_q | storageMismatch;
        end
    end

    assign err_storage = errStorage_q;
`else
    assign err_storage = storageMismatch;
`endif

    assign q          = committed_q;
    assign qs         = committed_q;
    assign phase      = phase_q;
    assign qe         = qe_q;
    assign err_update = errUpdate_q;

endmodule
